rx_pair_deserializer: RTL and testbench

Input stage of the Viterbi decoder. It converts the hard-decision serial channel bit stream into framed 2-bit code-symbol pairs (`out_pair`), which feed the branch-metric units. It tracks frame boundaries with a pair counter, flags synchronisation errors, and buffers pairs so the downstream trellis can stall without dropping channel data.

---
 rtl/rx_pair_deserializer.sv | 135 +++++++++++++
 tb/tb_rx_pair_deserializer.sv | 220 ++++++++++++++++++++++
 2 files changed

// File: rtl/rx_pair_deserializer.sv
// Serial hard-decision bits -> framed 2-bit code pairs with sof/eof tags and sync-error detection.
// Define RX_PAIR_FIFO_EN to buffer pairs in a FIFO_DEPTH-entry FIFO instead of a single output register.
module rx_pair_deserializer #(
  parameter int FRAME_PAIRS = 70,
  parameter int FIFO_DEPTH  = 4
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       in_bit,
  input  logic       in_valid,
  input  logic       in_sof,
  output logic       in_ready,
  output logic [1:0] out_pair,
  output logic       out_valid,
  input  logic       out_ready,
  output logic       out_sof,
  output logic       out_eof,
  output logic       sync_err,
  output logic       frame_busy
);

  localparam int CW = (FRAME_PAIRS > 1) ? $clog2(FRAME_PAIRS) : 1;
  localparam logic [CW-1:0] LAST_IDX = CW'(FRAME_PAIRS - 1);

  typedef enum logic [1:0] {IDLE, FIRST, SECOND} state_t;

  if (FRAME_PAIRS < 2 || FRAME_PAIRS > 1023 ||
      FIFO_DEPTH < 2 || (FIFO_DEPTH & (FIFO_DEPTH - 1)) != 0) begin : g_bad_params
    $error("rx_pair_deserializer: illegal FRAME_PAIRS or FIFO_DEPTH");
  end

  state_t        state;
  logic          bit0;
  logic [CW-1:0] cnt;
  logic          space;
  logic          accept;
  logic          push;
  logic          pop;
  logic [3:0]    entry;

  // A queue with no room only blocks the bit that would complete a pair.
  assign in_ready   = (state != SECOND) || space;
  assign accept     = in_valid && in_ready;
  assign push       = accept && (state == SECOND) && !in_sof;
  assign pop        = out_valid && out_ready;
  assign frame_busy = (state != IDLE);
  assign entry      = {cnt == LAST_IDX, cnt == '0, in_bit, bit0};

  // NOTE: every sequential assignment uses <= so all registers update from pre-edge values.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= IDLE;
      bit0     <= 1'b0;
      cnt      <= '0;
      sync_err <= 1'b0;
    end else begin
      sync_err <= 1'b0;
      if (accept) begin
        if (in_sof) begin
          // A sof inside a frame aborts it; the partial pair is simply overwritten.
          sync_err <= (state != IDLE);
          bit0     <= in_bit;
          cnt      <= '0;
          state    <= SECOND;
        end else begin
          case (state)
            IDLE: ;
            FIRST: begin
              bit0  <= in_bit;
              state <= SECOND;
            end
            SECOND: begin
              if (cnt == LAST_IDX) begin
                state <= IDLE;
              end else begin
                cnt   <= cnt + 1'b1;
                state <= FIRST;
              end
            end
            default: state <= IDLE;
          endcase
        end
      end
    end
  end

`ifdef RX_PAIR_FIFO_EN
  localparam int AW = $clog2(FIFO_DEPTH);

  logic [3:0]  mem [FIFO_DEPTH];
  logic [AW:0] wr_ptr;
  logic [AW:0] rd_ptr;
  logic        full;
  logic [3:0]  head;

  assign full      = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
  assign out_valid = (wr_ptr != rd_ptr);
  assign space     = !full;
  assign head      = mem[rd_ptr[AW-1:0]];
  assign {out_eof, out_sof, out_pair} = out_valid ? head : 4'b0;

  // NOTE: storage is not reset; out_valid gates every read, so stale contents are never visible.
  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr[AW-1:0]] <= entry;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop)  rd_ptr <= rd_ptr + 1'b1;
    end
  end
`else
  // A new pair may replace the one being popped in the same cycle.
  assign space = !out_valid || out_ready;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_valid <= 1'b0;
      out_pair  <= 2'b00;
      out_sof   <= 1'b0;
      out_eof   <= 1'b0;
    end else if (push) begin
      out_valid <= 1'b1;
      {out_eof, out_sof, out_pair} <= entry;
    end else if (pop) begin
      out_valid <= 1'b0;
    end
  end
`endif

endmodule

// File: tb/tb_rx_pair_deserializer.sv
// Self-checking bench for rx_pair_deserializer: directed scenarios plus randomized traffic
// scored against a bit-index reference model; a second instance covers FRAME_PAIRS=2.
module tb_rx_pair_deserializer;

  localparam int FP = 70;
`ifdef RX_PAIR_FIFO_EN
  localparam int QDEPTH = 4;
`else
  localparam int QDEPTH = 1;
`endif

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       in_bit = 1'b0, in_valid = 1'b0, in_sof = 1'b0, out_ready = 1'b0;
  logic       in_ready, out_valid, out_sof, out_eof, sync_err, frame_busy;
  logic [1:0] out_pair;

  logic       b2 = 1'b0, v2 = 1'b0, s2 = 1'b0, r2 = 1'b0;
  logic       rdy2, ov2, osof2, oeof2, se2, fb2;
  logic [1:0] op2;

  always #5 clk = ~clk;

  rx_pair_deserializer #(.FRAME_PAIRS(FP), .FIFO_DEPTH(4)) dut (
    .clk(clk), .rst_n(rst_n), .in_bit(in_bit), .in_valid(in_valid), .in_sof(in_sof),
    .in_ready(in_ready), .out_pair(out_pair), .out_valid(out_valid), .out_ready(out_ready),
    .out_sof(out_sof), .out_eof(out_eof), .sync_err(sync_err), .frame_busy(frame_busy)
  );

  rx_pair_deserializer #(.FRAME_PAIRS(2), .FIFO_DEPTH(4)) dut2 (
    .clk(clk), .rst_n(rst_n), .in_bit(b2), .in_valid(v2), .in_sof(s2),
    .in_ready(rdy2), .out_pair(op2), .out_valid(ov2), .out_ready(r2),
    .out_sof(osof2), .out_eof(oeof2), .sync_err(se2), .frame_busy(fb2)
  );

  int n_checks = 0;
  int n_pass   = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
  endtask

  // Reference model: position of each accepted bit inside its frame decides everything.
  logic [3:0] exp_q[$];   // {eof, sof, pair}
  bit         in_frame;
  int         pos;
  logic       prev_bit;
  logic       exp_sync;
  int         eof_seen, sof_seen, sync_seen;
  logic       last_rdy;

  function automatic void model_accept(input logic b, input logic s);
    if (s) begin
      if (in_frame) exp_sync = 1'b1;
      in_frame = 1'b1;
      pos = 0;
    end
    if (!in_frame) return;
    if (pos % 2 == 0) begin
      prev_bit = b;
    end else begin
      exp_q.push_back({pos == 2*FP - 1, pos == 1, b, prev_bit});
      if (pos == 2*FP - 1) in_frame = 1'b0;
    end
    pos++;
  endfunction

  task automatic cycle(input logic v, input logic b, input logic s, input logic r);
    logic [3:0] e;
    @(negedge clk);
    in_valid = v; in_bit = b; in_sof = s; out_ready = r;
    #1;
    last_rdy = in_ready;
    check("sync_err", sync_err, exp_sync);
    if (sync_err) sync_seen++;
    exp_sync = 1'b0;
    if (out_valid && out_ready) begin
      if (exp_q.size() == 0) begin
        check("spurious_pair", out_valid, exp_q.size() != 0);
      end else begin
        e = exp_q.pop_front();
        check("pair", {out_eof, out_sof, out_pair}, e);
        if (out_eof) eof_seen++;
        if (out_sof) sof_seen++;
      end
    end
    if (in_valid && in_ready) model_accept(b, s);
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst_n = 1'b0;
    in_valid = 0; in_bit = 0; in_sof = 0; out_ready = 0;
    #1;
    check("rst_out_valid", out_valid, 0);
    check("rst_out_pair", out_pair, 0);
    check("rst_sof_eof", {out_sof, out_eof}, 0);
    check("rst_sync_err", sync_err, 0);
    check("rst_frame_busy", frame_busy, 0);
    check("rst_in_ready", in_ready, 1);
    exp_q.delete();
    in_frame = 0; pos = 0; exp_sync = 0;
    eof_seen = 0; sof_seen = 0; sync_seen = 0;
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic drain();
    for (int i = 0; i < 40 && exp_q.size() != 0; i++) cycle(0, 0, 0, 1);
    check("drain_empty", exp_q.size(), 0);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

  initial begin
    logic [3:0]  held;
    logic [11:0] bits2;
    logic [3:0]  q2[$];
    logic [3:0]  e2;

    do_reset();

    // Bits 1,0,1,1 -> 2'b01 (sof) then 2'b11, each one cycle after its second bit.
    cycle(1, 1, 1, 1);
    cycle(1, 0, 0, 1);
    cycle(1, 1, 0, 1);
    check("t1_latency0", out_valid, 1);
    check("t1_pair0", {out_sof, out_pair}, 3'b101);
    cycle(1, 1, 0, 1);
    cycle(0, 0, 0, 1);
    check("t1_latency1", out_valid, 1);
    check("t1_pair1", {out_sof, out_pair}, 3'b011);
    check("t1_busy", frame_busy, 1);

    // Full frame: sof only on pair 0, eof only on pair 69; trailing bit dropped.
    do_reset();
    for (int i = 0; i < 2*FP; i++) cycle(1, 1'($urandom), i == 0, 1);
    cycle(1, 1, 0, 1);
    check("t2_busy_fell", frame_busy, 0);
    for (int i = 0; i < 3; i++) cycle(0, 0, 0, 1);
    check("t2_dropped", out_valid, 0);
    check("t2_eof_count", eof_seen, 1);
    check("t2_sof_count", sof_seen, 1);
    check("t2_model_empty", exp_q.size(), 0);

    // Back-pressure: in_ready drops in SECOND once the queue is full.
    do_reset();
    for (int i = 0; i < 40; i++) begin
      cycle(1, 1'($urandom), i == 0, 0);
      if (!last_rdy) break;
    end
    check("t3_in_ready_low", last_rdy, 0);
    check("t3_depth", exp_q.size(), QDEPTH);
    check("t3_in_second", pos % 2, 1);
    held = {out_eof, out_sof, out_pair};
    for (int i = 0; i < 3; i++) cycle(1, 1'($urandom), 0, 0);
    check("t3_hold", {out_eof, out_sof, out_pair}, held);
    check("t3_still_blocked", last_rdy, 0);
    for (int i = 0; i < 400 && in_frame; i++) cycle(1, 1'($urandom), 0, 1);
    drain();
    check("t3_eof_count", eof_seen, 1);

    // sof on bit 21 (second bit of pair 10): abort, then a complete new frame.
    do_reset();
    for (int i = 0; i < 21; i++) cycle(1, 1'($urandom), i == 0, 1);
    for (int i = 0; i < 2*FP; i++) cycle(1, 1'($urandom), i == 0, 1);
    drain();
    check("t4_sync_pulses", sync_seen, 1);
    check("t4_eof_count", eof_seen, 1);
    check("t4_sof_count", sof_seen, 2);

    // Reset with pairs queued: everything discarded at once.
    do_reset();
    for (int i = 0; i < 6; i++) cycle(1, 1'($urandom), i == 0, 0);
    check("t5_queued", out_valid, 1);
    do_reset();
    for (int i = 0; i < 4; i++) cycle(0, 0, 0, 1);
    check("t5_no_stale", out_valid, 0);

    // Randomized traffic with occasional early sof and random stalls.
    do_reset();
    for (int i = 0; i < 2500; i++) begin
      logic s;
      s = in_frame ? ($urandom_range(0, 199) == 0) : ($urandom_range(0, 3) == 0);
      cycle($urandom_range(0, 3) != 0, 1'($urandom), s, $urandom_range(0, 3) != 0);
    end
    drain();
    check("t6_some_frames", eof_seen > 3, 1);

    // FRAME_PAIRS=2: three back-to-back frames, sof/eof alternate.
    for (int i = 0; i < 12; i++) bits2[i] = 1'($urandom);
    for (int k = 0; k < 6; k++) q2.push_back({k % 2 == 1, k % 2 == 0, bits2[2*k+1], bits2[2*k]});
    for (int i = 0; i < 15; i++) begin
      @(negedge clk);
      v2 = (i < 12); b2 = (i < 12) ? bits2[i] : 1'b0; s2 = (i < 12) && (i % 4 == 0); r2 = 1'b1;
      #1;
      check("fp2_sync", se2, 0);
      if (i < 12) check("fp2_in_ready", rdy2, 1);
      if (ov2 && r2) begin
        if (q2.size() == 0) begin
          check("fp2_spurious", ov2, q2.size() != 0);
        end else begin
          e2 = q2.pop_front();
          check("fp2_pair", {oeof2, osof2, op2}, e2);
        end
      end
    end
    check("fp2_all_delivered", q2.size(), 0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
